// File: rtl/writeback_pkg.sv
// Shared RV32I constants and the Memory/Writeback pipeline register bundle.
// Imported by the writeback stage and its load alignment helper.
package writeback_pkg;

   localparam logic [4:0]  ZERO_REG_ADDR = 5'd0;
   localparam logic [31:0] ZERO_REG_DATA = 32'h0000_0000;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;

   typedef struct packed {
      logic [4:0]  rd;
      logic        wr_en;
      logic [31:0] data;
      logic        is_load;
      logic [2:0]  funct3;
      logic [1:0]  lsb;
   } mem_wb_t;

endpackage

// File: rtl/writeback_load_align.sv
// Selects and extends the addressed byte/half of a raw load word.
// Reserved funct3 codes fall through to a full-word load.
module load_align
   import writeback_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lsb,
   input  logic [31:0] rd_data,
   output logic [31:0] aligned
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rd_data[7:0];
      unique case (addr_lsb)
         2'd0: byte_sel = rd_data[7:0];
         2'd1: byte_sel = rd_data[15:8];
         2'd2: byte_sel = rd_data[23:16];
         2'd3: byte_sel = rd_data[31:24];
      endcase
      half_sel = addr_lsb[1] ? rd_data[31:16] : rd_data[15:0];
      case (funct3)
         LB:      aligned = {{24{byte_sel[7]}}, byte_sel};
         LH:      aligned = {{16{half_sel[15]}}, half_sel};
         LBU:     aligned = {24'h0, byte_sel};
         LHU:     aligned = {16'h0, half_sel};
         default: aligned = rd_data;
      endcase
   end

endmodule

// File: rtl/writeback.sv
// RV32I writeback stage: M/WB register, load wait and alignment,
// register-file write port and forwarding outputs.
module writeback
   import writeback_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        memory_clk_en,
   input  logic [4:0]  memory_in_rd,
   input  logic        memory_in_rd_wr_en,
   input  logic [31:0] memory_in_rd_wr_data,
   input  logic        memory_in_is_load,
   input  logic [2:0]  memory_in_funct3,
   input  logic [1:0]  memory_in_addr_lsb,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rd_data,
   input  logic        writeback_flush,
   output logic        stall_writeback,
   output logic [4:0]  memory_rd,
   output logic        memory_rd_wr_en,
   output logic [31:0] writeback_rd_wr_data,
   output logic        writeback_clk_en,
   output logic        regs_wr_en,
   output logic [4:0]  regs_wr_addr,
   output logic        writeback_retire
);

   typedef enum logic {
      IDLE     = 1'b0,
      WAIT_ACK = 1'b1
   } state_t;

   state_t      state_q;
   state_t      state_d;
   mem_wb_t     wb;
   logic        wb_valid;
   logic        capture;
   logic        ack_take;
   logic [31:0] aligned;

   assign stall_writeback = (state_q == WAIT_ACK);
   assign capture  = memory_clk_en && !stall_writeback
                  && !writeback_flush;
   assign ack_take = stall_writeback && dmem_ack
                  && wb.is_load && !writeback_flush;

   load_align u_align (
      .funct3   (wb.funct3),
      .addr_lsb (wb.lsb),
      .rd_data  (dmem_rd_data),
      .aligned  (aligned)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (writeback_flush) begin
         state_d = IDLE;
      end else if (capture) begin
         state_d = memory_in_is_load ? WAIT_ACK : IDLE;
      end else if (ack_take) begin
         state_d = IDLE;
      end
   end

   // A waiting load keeps wb_valid so it can commit once the ack lands.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wb_valid <= 1'b0;
         wb       <= '0;
      end else if (writeback_flush) begin
         wb_valid <= 1'b0;
      end else if (capture) begin
         wb_valid   <= 1'b1;
         wb.rd      <= memory_in_rd;
         wb.wr_en   <= memory_in_rd_wr_en;
         wb.data    <= memory_in_rd_wr_data;
         wb.is_load <= memory_in_is_load;
         wb.funct3  <= memory_in_funct3;
         wb.lsb     <= memory_in_addr_lsb;
      end else if (ack_take) begin
         wb.data <= aligned;
      end else if (!stall_writeback) begin
         wb_valid <= 1'b0;
      end
   end

   assign writeback_clk_en     = wb_valid && !stall_writeback;
   assign writeback_retire     = writeback_clk_en;
   assign regs_wr_en           = writeback_clk_en && wb.wr_en
                              && (wb.rd != ZERO_REG_ADDR);
   assign regs_wr_addr         = wb.rd;
   assign memory_rd            = wb.rd;
   assign memory_rd_wr_en      = wb.wr_en;
   assign writeback_rd_wr_data = wb.data;

endmodule
